isb_prefetch_ctrl: RTL and testbench
====================================

// Module: isb_prefetch_ctrl
// PURPOSE
//  Sequencer for the ISB stream predictor.
//  - On a trigger (PS-AMC hit giving a structural address SA), walks SP-AMC for
//    SA+1..SA+DEGREE and buffers each hit's physical address in a DEPTH-entry FIFO.
//  - Drains the FIFO to the prefetch port under a valid/ready handshake.
//  - Sits between the ISB training/lookup tables and the memory-side prefetch port.
// PARAMETERS
//  DEPTH   4   stream-buffer FIFO entries; power of 2, >= 2
//  DEGREE  1   SP-AMC lookups per trigger, 1..4
//  SA_W    32  structural address width
//  PA_W    16  physical address width
//  MAX_SA  32  structural address space bound; SA >= MAX_SA is never requested
// PORTS
//  clk            in   1     clock, all state updates on posedge
//  rst_n          in   1     synchronous active-low reset
//  trig_v         in   1     trigger valid (single-cycle pulse)
//  trig_sa        in   SA_W  structural address of the triggering access
//  sp_req_v       out  1     SP-AMC read request valid
//  sp_req_sa      out  SA_W  SA to look up
//  sp_req_rdy     in   1     SP-AMC accepts request
//  sp_rsp_v       in   1     SP-AMC response valid
//  sp_rsp_hit     in   1     response hit (entry valid, tag match)
//  sp_rsp_pa      in   PA_W  mapped physical address
//  prefetch_v     out  1     prefetch address valid (= FIFO not empty)
//  prefetch_addr  out  PA_W  FIFO head
//  prefetch_rdy   in   1     consumer accepts prefetch
//  busy           out  1     FSM not IDLE
//  drop_cnt       out  8     saturating count of dropped triggers and dropped PAs
// BEHAVIOUR
//  Reset: rst_n=0 at a posedge -> state IDLE, FIFO empty, drop_cnt=0.
//   All outputs 0 the following cycle, including during a walk.
//   A response arriving after reset is ignored; sp_rsp_v is ignored outside WAIT.
//  FSM: IDLE -> REQ -> WAIT -> (REQ | IDLE); regs cur_sa[SA_W], n[2:0].
//  IDLE:
//   - trig_v=1 and trig_sa+1 < MAX_SA: cur_sa <= trig_sa+1, n <= 0, go REQ.
//   - trig_sa+1 >= MAX_SA: trigger ignored, not counted.
//   - trig_sa+1 uses SA_W-bit arithmetic; a carry out of SA_W counts as out of range.
//  REQ: sp_req_v=1, sp_req_sa=cur_sa held stable until sp_req_rdy=1, then go WAIT.
//  WAIT: sp_req_v=0. On sp_rsp_v=1:
//   - hit, and (FIFO not full or pop this cycle): push sp_rsp_pa.
//   - hit, FIFO full, no pop: PA dropped, drop_cnt++.
//   - miss: nothing pushed.
//   - if n == DEGREE-1 or cur_sa+1 >= MAX_SA: go IDLE.
//   - else: n++, cur_sa++, go REQ.
//  trig_v while busy=1: ignored, drop_cnt++; the walk in progress is unaffected.
//  Latency: trigger at edge N -> sp_req_v high in cycle N+1.
//   Push at edge M -> prefetch_v high in cycle M+1.
//  FIFO:
//   - pop when prefetch_v && prefetch_rdy.
//   - push and pop in the same cycle are both performed; allowed when full or
//     when count=1.
//   - empty with push: data visible next cycle, no bypass.
//   - Pointers wrap modulo DEPTH; occupancy held in a log2(DEPTH)+1 bit counter.
//   - prefetch_addr is stable while prefetch_v && !prefetch_rdy.
//  drop_cnt: saturates at 8'hFF. A trigger drop and a PA drop in the same cycle
//   add 2, capped at 8'hFF.
//  busy = (state != IDLE).
// TESTING
//  1 Reset, trig_v with sa=5, SP hit pa=16'h00A3, prefetch_rdy=1
//    -> sp_req_sa=6 one cycle after trigger; prefetch_addr=00A3 the cycle after
//       the response; FIFO empty after the pop.
//  2 DEGREE=4, trig sa=8, all hits pa=100..103, prefetch_rdy=0
//    -> requests sa 9,10,11,12 in order; FIFO holds 100..103; busy falls after
//       the 4th response.
//  3 FIFO full, prefetch_rdy=0, trigger with a hit
//    -> PA dropped, drop_cnt=1.
//    Repeat with prefetch_rdy=1 on the response cycle -> push accepted, no drop.
//  4 trig sa=31 -> no request, busy=0.
//    DEGREE=4, trig sa=29 -> requests 30,31 only, then IDLE.
//  5 Trigger while in WAIT -> ignored, drop_cnt++, walk completes normally.
//    sp_req_rdy held low 5 cycles -> sp_req_sa stable throughout.
//  6 rst_n=0 in WAIT, response arrives after reset
//    -> no push, prefetch_v=0, busy=0, drop_cnt=0.

Source files
------------

// File: rtl/isb_prefetch_ctrl.sv
// ISB prefetch sequencer: a trigger SA starts a walk of SP-AMC over SA+1..SA+DEGREE.
// Each hit's physical address is buffered in a small FIFO, which drains to the prefetch port.
module isb_prefetch_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DEGREE = 1,
  parameter int unsigned SA_W   = 32,
  parameter int unsigned PA_W   = 16,
  parameter int unsigned MAX_SA = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trig_v,
  input  logic [SA_W-1:0] trig_sa,
  output logic            sp_req_v,
  output logic [SA_W-1:0] sp_req_sa,
  input  logic            sp_req_rdy,
  input  logic            sp_rsp_v,
  input  logic            sp_rsp_hit,
  input  logic [PA_W-1:0] sp_rsp_pa,
  output logic            prefetch_v,
  output logic [PA_W-1:0] prefetch_addr,
  input  logic            prefetch_rdy,
  output logic            busy,
  output logic [7:0]      drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [SA_W:0] MAX_EXT = (SA_W+1)'(MAX_SA);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          state, state_d;
  logic [SA_W-1:0] cur_sa, cur_sa_d;
  logic [2:0]      n, n_d;

  logic [PA_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  logic            empty, full, push, pop, rsp_hit, drop_pa, drop_trig;
  logic [SA_W:0]   trig_nxt, cur_nxt;
  logic [8:0]      drop_sum;

  // One extra bit so a carry out of SA_W compares as out of range.
  assign trig_nxt = {1'b0, trig_sa} + (SA_W+1)'(1);
  assign cur_nxt  = {1'b0, cur_sa} + (SA_W+1)'(1);

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop       = !empty && prefetch_rdy;
  assign rsp_hit   = (state == S_WAIT) && sp_rsp_v && sp_rsp_hit;
  assign push      = rsp_hit && (!full || pop);
  assign drop_pa   = rsp_hit && full && !pop;
  assign drop_trig = trig_v && (state != S_IDLE);
  assign drop_sum  = {1'b0, drop_cnt} + {8'd0, drop_trig} + {8'd0, drop_pa};

  assign busy          = (state != S_IDLE);
  assign prefetch_v    = !empty;
  assign prefetch_addr = empty ? '0 : mem[rd_ptr];

  always_comb begin
    state_d   = state;
    cur_sa_d  = cur_sa;
    n_d       = n;
    sp_req_v  = 1'b0;
    sp_req_sa = '0;
    case (state)
      S_IDLE: begin
        if (trig_v && (trig_nxt < MAX_EXT)) begin
          cur_sa_d = trig_nxt[SA_W-1:0];
          n_d      = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        sp_req_v  = 1'b1;
        sp_req_sa = cur_sa;
        if (sp_req_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sp_rsp_v) begin
          if ((n == 3'(DEGREE - 1)) || (cur_nxt >= MAX_EXT)) begin
            state_d = S_IDLE;
          end else begin
            n_d      = n + 3'd1;
            cur_sa_d = cur_nxt[SA_W-1:0];
            state_d  = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur_sa   <= '0;
      n        <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_d;
      cur_sa   <= cur_sa_d;
      n        <= n_d;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sp_rsp_pa;
  end

endmodule

// File: tb/tb_isb_prefetch_ctrl.sv
// Bench for isb_prefetch_ctrl: directed scenarios plus a randomized run, all checked
// against a queue-based model of the walk list, the stream FIFO and the drop counter.
module tb_isb_prefetch_ctrl;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DEGREE = 4;
  localparam int unsigned MAX_SA = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig_v = 1'b0;
  logic [31:0] trig_sa = '0;
  logic        sp_req_rdy = 1'b0;
  logic        sp_rsp_v = 1'b0;
  logic        sp_rsp_hit = 1'b0;
  logic [15:0] sp_rsp_pa = '0;
  logic        prefetch_rdy = 1'b0;
  logic        sp_req_v, prefetch_v, busy;
  logic [31:0] sp_req_sa;
  logic [15:0] prefetch_addr;
  logic [7:0]  drop_cnt;

  int nchk = 0;
  int npass = 0;

  // Model: SAs still to look up, whether one is in flight, FIFO contents, drop total.
  logic [31:0] sa_q[$];
  logic [15:0] fq[$];
  bit          outst = 1'b0;
  int          mdrop = 0;

  isb_prefetch_ctrl #(
    .DEPTH(DEPTH), .DEGREE(DEGREE), .SA_W(32), .PA_W(16), .MAX_SA(MAX_SA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trig_v(trig_v), .trig_sa(trig_sa),
    .sp_req_v(sp_req_v), .sp_req_sa(sp_req_sa), .sp_req_rdy(sp_req_rdy),
    .sp_rsp_v(sp_rsp_v), .sp_rsp_hit(sp_rsp_hit), .sp_rsp_pa(sp_rsp_pa),
    .prefetch_v(prefetch_v), .prefetch_addr(prefetch_addr), .prefetch_rdy(prefetch_rdy),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [58:0] expv();
    bit r = (sa_q.size() != 0) && !outst;
    bit f = (fq.size() != 0);
    return {r, r ? sa_q[0] : 32'd0, f, f ? fq[0] : 16'd0,
            (sa_q.size() != 0) || outst, 8'(mdrop)};
  endfunction

  function automatic logic [58:0] obsv();
    return {sp_req_v, sp_req_v ? sp_req_sa : 32'd0, prefetch_v,
            prefetch_v ? prefetch_addr : 16'd0, busy, drop_cnt};
  endfunction

  // Advance the model with the inputs presented this cycle, then clock the DUT.
  task automatic step();
    bit mbusy = (sa_q.size() != 0) || outst;
    bit mreq  = (sa_q.size() != 0) && !outst;
    bit pop   = (fq.size() != 0) && prefetch_rdy;
    int fsz   = fq.size();
    if (!rst_n) begin
      sa_q.delete(); fq.delete(); outst = 1'b0; mdrop = 0;
    end else begin
      if (trig_v && mbusy) begin
        if (mdrop < 255) mdrop++;
      end else if (trig_v && (longint'(trig_sa) + 1 < MAX_SA)) begin
        for (longint s = longint'(trig_sa) + 1;
             s <= longint'(trig_sa) + DEGREE && s < MAX_SA; s++)
          sa_q.push_back(32'(s));
      end
      if (pop) void'(fq.pop_front());
      if (outst && sp_rsp_v) begin
        if (sp_rsp_hit) begin
          if (fsz < DEPTH || pop) fq.push_back(sp_rsp_pa);
          else if (mdrop < 255) mdrop++;
        end
        void'(sa_q.pop_front());
        outst = 1'b0;
      end else if (mreq && sp_req_rdy) begin
        outst = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Accept the pending request, then answer it on the following cycle.
  task automatic serve(input bit hit, input logic [15:0] pa);
    sp_req_rdy = 1'b1;
    step();
    sp_req_rdy = 1'b0;
    sp_rsp_v = 1'b1; sp_rsp_hit = hit; sp_rsp_pa = pa;
    step();
    sp_rsp_v = 1'b0; sp_rsp_hit = 1'b0; sp_rsp_pa = '0;
  endtask

  task automatic trigger(input logic [31:0] sa);
    trig_v = 1'b1; trig_sa = sa;
    step();
    trig_v = 1'b0; trig_sa = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    nchk++; if (obsv() !== expv()) $display("FAIL reset_model: got %h exp %h", obsv(), expv()); else npass++;
    nchk++; if (obsv() !== 59'd0) $display("FAIL reset_zero: got %h exp 0", obsv()); else npass++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    prefetch_rdy = 1'b1;
    trigger(32'd5);
    nchk++; if (!sp_req_v || sp_req_sa !== 32'd6) $display("FAIL single_req: got v=%b sa=%0d exp v=1 sa=6", sp_req_v, sp_req_sa); else npass++;
    serve(1'b1, 16'h00A3);
    nchk++; if (!prefetch_v || prefetch_addr !== 16'h00A3) $display("FAIL single_pa: got v=%b addr=%h exp v=1 addr=00a3", prefetch_v, prefetch_addr); else npass++;
    nchk++; if (obsv() !== expv()) $display("FAIL single_model: got %h exp %h", obsv(), expv()); else npass++;
    serve(1'b0, '0);
    nchk++; if (prefetch_v !== 1'b0) $display("FAIL single_empty: got prefetch_v=%b exp 0", prefetch_v); else npass++;
    serve(1'b0, '0); serve(1'b0, '0);
    nchk++; if (obsv() !== expv() || busy !== 1'b0) $display("FAIL single_end: got %h exp %h", obsv(), expv()); else npass++;
    prefetch_rdy = 1'b0;
  endtask

  task automatic test_degree_walk();
    trigger(32'd8);
    for (int i = 0; i < 4; i++) begin
      nchk++; if (!sp_req_v || sp_req_sa !== 32'(9 + i)) $display("FAIL walk_req%0d: got v=%b sa=%0d exp sa=%0d", i, sp_req_v, sp_req_sa, 9 + i); else npass++;
      serve(1'b1, 16'(100 + i));
      nchk++; if (obsv() !== expv()) $display("FAIL walk_model%0d: got %h exp %h", i, obsv(), expv()); else npass++;
    end
    nchk++; if (busy !== 1'b0 || prefetch_addr !== 16'd100) $display("FAIL walk_end: got busy=%b addr=%0d exp busy=0 addr=100", busy, prefetch_addr); else npass++;
  endtask

  task automatic test_full_drop();
    logic [15:0] order [4] = '{16'd101, 16'd102, 16'd103, 16'h0066};
    trigger(32'd0);
    serve(1'b1, 16'h0055);
    nchk++; if (drop_cnt !== 8'd1) $display("FAIL full_drop: got drop_cnt=%0d exp 1", drop_cnt); else npass++;
    for (int i = 0; i < 3; i++) serve(1'b0, '0);
    trigger(32'd0);
    sp_req_rdy = 1'b1; step(); sp_req_rdy = 1'b0;
    sp_rsp_v = 1'b1; sp_rsp_hit = 1'b1; sp_rsp_pa = 16'h0066; prefetch_rdy = 1'b1;
    step();
    sp_rsp_v = 1'b0; sp_rsp_hit = 1'b0; prefetch_rdy = 1'b0;
    nchk++; if (drop_cnt !== 8'd1 || prefetch_addr !== 16'd101) $display("FAIL full_poppush: got drop=%0d addr=%0d exp drop=1 addr=101", drop_cnt, prefetch_addr); else npass++;
    for (int i = 0; i < 3; i++) serve(1'b0, '0);
    nchk++; if (obsv() !== expv()) $display("FAIL full_model: got %h exp %h", obsv(), expv()); else npass++;
    for (int i = 0; i < 4; i++) begin
      nchk++; if (!prefetch_v || prefetch_addr !== order[i]) $display("FAIL full_drain%0d: got addr=%h exp %h", i, prefetch_addr, order[i]); else npass++;
      prefetch_rdy = 1'b1; step(); prefetch_rdy = 1'b0;
    end
    nchk++; if (prefetch_v !== 1'b0) $display("FAIL full_empty: got prefetch_v=%b exp 0", prefetch_v); else npass++;
  endtask

  task automatic test_range();
    trigger(32'd31);
    nchk++; if (busy !== 1'b0 || sp_req_v !== 1'b0) $display("FAIL range_31: got busy=%b req=%b exp 0 0", busy, sp_req_v); else npass++;
    trigger(32'hFFFF_FFFF);
    nchk++; if (obsv() !== expv() || busy !== 1'b0) $display("FAIL range_wrap: got %h exp %h", obsv(), expv()); else npass++;
    trigger(32'd29);
    nchk++; if (sp_req_sa !== 32'd30) $display("FAIL range_req30: got sa=%0d exp 30", sp_req_sa); else npass++;
    serve(1'b0, '0);
    nchk++; if (sp_req_sa !== 32'd31) $display("FAIL range_req31: got sa=%0d exp 31", sp_req_sa); else npass++;
    serve(1'b0, '0);
    nchk++; if (busy !== 1'b0 || obsv() !== expv()) $display("FAIL range_end: got %h exp %h", obsv(), expv()); else npass++;
  endtask

  task automatic test_busy_trigger();
    trigger(32'd3);
    for (int i = 0; i < 5; i++) begin
      step();
      nchk++; if (!sp_req_v || sp_req_sa !== 32'd4) $display("FAIL stall%0d: got v=%b sa=%0d exp v=1 sa=4", i, sp_req_v, sp_req_sa); else npass++;
    end
    sp_req_rdy = 1'b1; step(); sp_req_rdy = 1'b0;
    trigger(32'd10);
    nchk++; if (drop_cnt !== 8'd2 || busy !== 1'b1) $display("FAIL busy_trig: got drop=%0d busy=%b exp 2 1", drop_cnt, busy); else npass++;
    sp_rsp_v = 1'b1; step(); sp_rsp_v = 1'b0;
    nchk++; if (sp_req_sa !== 32'd5) $display("FAIL busy_next: got sa=%0d exp 5", sp_req_sa); else npass++;
    for (int i = 0; i < 3; i++) serve(1'b0, '0);
    nchk++; if (busy !== 1'b0 || obsv() !== expv()) $display("FAIL busy_end: got %h exp %h", obsv(), expv()); else npass++;
  endtask

  task automatic test_reset_in_wait();
    trigger(32'd1);
    sp_req_rdy = 1'b1; step(); sp_req_rdy = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    sp_rsp_v = 1'b1; sp_rsp_hit = 1'b1; sp_rsp_pa = 16'h0077;
    step();
    sp_rsp_v = 1'b0; sp_rsp_hit = 1'b0;
    nchk++; if (obsv() !== 59'd0) $display("FAIL rstwait_zero: got %h exp 0", obsv()); else npass++;
    step();
    nchk++; if (obsv() !== expv()) $display("FAIL rstwait_model: got %h exp %h", obsv(), expv()); else npass++;
  endtask

  task automatic test_saturation();
    trigger(32'd0);
    trig_v = 1'b1;
    for (int i = 0; i < 300; i++) begin
      trig_sa = $urandom_range(0, 40);
      step();
    end
    trig_v = 1'b0;
    nchk++; if (drop_cnt !== 8'hFF) $display("FAIL saturate: got drop=%0d exp 255", drop_cnt); else npass++;
    rst_n = 1'b0; step(); rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      rst_n        = ($urandom_range(0, 599) != 0);
      trig_v       = ($urandom_range(0, 5) == 0);
      trig_sa      = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 2)
                                                  : 32'($urandom_range(0, 40));
      sp_req_rdy   = $urandom_range(0, 1);
      sp_rsp_v     = $urandom_range(0, 1);
      sp_rsp_hit   = ($urandom_range(0, 3) != 0);
      sp_rsp_pa    = 16'($urandom);
      prefetch_rdy = ($urandom_range(0, 4) < 2);
      step();
      nchk++; if (obsv() !== expv()) $display("FAIL random_%0d: got %h exp %h", i, obsv(), expv()); else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_degree_walk();
    test_full_drop();
    test_range();
    test_busy_trigger();
    test_reset_in_wait();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
